// File: rtl/router_rd_arbiter.sv
// router_rd_arbiter: round-robin whole-packet read scheduler for three router FIFOs into one skid-buffered byte stream.
// Define RD_ARB_PARITY_CHK_EN to add the parity_err pulse on a mismatching parity beat.
module router_rd_arbiter #(
    parameter int NUM_SRC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] dout_0,
    input  logic [7:0] dout_1,
    input  logic [7:0] dout_2,
    output logic       rd_en_0,
    output logic       rd_en_1,
    output logic       rd_en_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_src
`ifdef RD_ARB_PARITY_CHK_EN
    ,
    output logic       parity_err
`endif
);
    typedef enum logic [1:0] {IDLE, HDR, PLD, DRAIN} state_t;
    localparam logic [1:0] LAST = 2'(NUM_SRC - 1);
`ifdef RD_ARB_PARITY_CHK_EN
    localparam int EW = 13;
`else
    localparam int EW = 12;
`endif
    state_t        state, state_nx;
    logic [1:0]    grant, grant_nx, rr_ptr, p1, p2, sel, cnt;
    logic [6:0]    remain, remain_nx;
    logic [2:0]    req;
    logic [7:0]    dout_g;
    logic          vld_g, rd, ret, credit, acc, pop, push, wp;
    logic [EW-1:0] q0, q1, in_beat, head;

    assign req    = {vld_out_2, vld_out_1, vld_out_0};
    assign p1     = (rr_ptr == LAST) ? 2'd0 : rr_ptr + 2'd1;
    assign p2     = (p1 == LAST) ? 2'd0 : p1 + 2'd1;
    assign sel    = req[rr_ptr] ? rr_ptr : req[p1] ? p1 : p2;
    assign vld_g  = (grant == 2'd2) ? vld_out_2 : (grant == 2'd1) ? vld_out_1 : vld_out_0;
    assign dout_g = (grant == 2'd2) ? dout_2 : (grant == 2'd1) ? dout_1 : dout_0;
    // a read is only in flight for one cycle, so credit = 2 - cnt - ret
    assign credit = (cnt == 2'd0) || (cnt == 2'd1 && !ret);

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        remain_nx = remain;
        rd        = 1'b0;
        case (state)
            IDLE: if (|req) begin
                grant_nx = sel;
                state_nx = HDR;
            end
            HDR: if (ret) begin
                remain_nx = {1'b0, dout_g[7:2]} + 7'd1;
                state_nx  = PLD;
            end else rd = vld_g && credit;
            PLD: begin
                rd        = remain != 7'd0 && vld_g && credit;
                remain_nx = remain - 7'(rd);
                if (remain_nx == 7'd0) state_nx = DRAIN;
            end
            DRAIN: state_nx = ret ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    assign rd_en_0 = rd && grant == 2'd0;
    assign rd_en_1 = rd && grant == 2'd1;
    assign rd_en_2 = rd && grant == 2'd2;

    // returning byte bypasses the skid when it is empty and the consumer takes it
    assign m_valid = cnt != 2'd0 || ret;
    assign acc     = m_valid && m_ready;
    assign pop     = acc && cnt != 2'd0;
    assign push    = ret && !(acc && cnt == 2'd0);
    assign wp      = cnt[0] ^ pop;
    assign head    = (cnt != 2'd0) ? q0 : ret ? in_beat : '0;
    assign m_data  = head[7:0];
    assign m_eop   = head[8];
    assign m_sop   = head[9];
    assign m_src   = head[11:10];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 2'd0;
            rr_ptr <= 2'd0;
            remain <= 7'd0;
            ret    <= 1'b0;
            cnt    <= 2'd0;
            q0     <= '0;
            q1     <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            remain <= remain_nx;
            ret    <= rd;
            if (state == DRAIN && ret) rr_ptr <= (grant == LAST) ? 2'd0 : grant + 2'd1;
            if (pop) q0 <= q1;
            if (push && wp) q1 <= in_beat;
            if (push && !wp) q0 <= in_beat;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

`ifdef RD_ARB_PARITY_CHK_EN
    logic [7:0] xsum;
    always_ff @(posedge clk) begin
        if (rst) xsum <= 8'd0;
        else if (ret && state == HDR) xsum <= dout_g;
        else if (ret && state == PLD) xsum <= xsum ^ dout_g;
    end
    // mismatch is judged on arrival and travels with the parity beat
    assign in_beat    = {dout_g != xsum, grant, state == HDR, state == DRAIN, dout_g};
    assign parity_err = acc && head[8] && head[12];
`else
    assign in_beat = {grant, state == HDR, state == DRAIN, dout_g};
`endif
endmodule

// File: tb/tb_router_rd_arbiter.sv
// tb_router_rd_arbiter: FIFO models plus a round-robin packet scoreboard checking every accepted beat.
module tb_router_rd_arbiter;
    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       bad;
    } beat_t;

    logic       clk = 1'b0, rst = 1'b1, m_ready = 1'b1;
    logic [2:0] vld = 3'b0, drop = 3'b0;
    wire  [2:0] rd;
    logic [7:0] d [3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0] m_data;
    logic       m_valid, m_sop, m_eop;
    logic [1:0] m_src;
    logic       perr;

    logic [7:0] fq [3][$];
    beat_t      ex [3][$];
    int nchk = 0, nerr = 0, cyc = 0, nacc = 0, lowrd = 0, perr_cnt = 0;
    int rdcnt [3] = '{0, 0, 0};
    int t_vld = -1, t_rd = -1, t_mv = -1;
    int acc_cyc[$], acc_dat[$], sop_src[$];
    int cs = 0, mptr = 0;
    logic locked = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [11:0] pbeat = '0;

    always #5 clk = ~clk;

    router_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .vld_out_0(vld[0]), .vld_out_1(vld[1]), .vld_out_2(vld[2]),
        .dout_0(d[0]), .dout_1(d[1]), .dout_2(d[2]),
        .rd_en_0(rd[0]), .rd_en_1(rd[1]), .rd_en_2(rd[2]),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_src(m_src)
`ifdef RD_ARB_PARITY_CHK_EN
        , .parity_err(perr)
`endif
    );
`ifndef RD_ARB_PARITY_CHK_EN
    assign perr = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // FIFO read ports: data one cycle after rd_en, vld reflects post-read contents
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) begin
                chk($sformatf("rd_when_vld_low%0d", i), vld[i], 1);
                if (fq[i].size() > 0) begin
                    d[i] <= fq[i][0];
                    void'(fq[i].pop_front());
                end
            end
            vld[i] <= fq[i].size() > 0 && !drop[i];
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) pv = 1'b0;
        else begin
            int s;
            beat_t e;
            chk("rd_onehot", $countones(rd) <= 1, 1);
            for (int i = 0; i < 3; i++) rdcnt[i] += rd[i];
            if (!m_ready) lowrd += rd[2];
            if (t_vld < 0 && vld[0]) t_vld = cyc;
            if (t_rd < 0 && rd[0]) t_rd = cyc;
            if (t_mv < 0 && m_valid) t_mv = cyc;
            if (pv && !pr) chk("hold", {m_valid, m_src, m_sop, m_eop, m_data}, {1'b1, pbeat});
            pv = m_valid;
            pr = m_ready;
            pbeat = {m_src, m_sop, m_eop, m_data};
            if (m_valid && m_ready) begin
                nacc++;
                acc_cyc.push_back(cyc);
                acc_dat.push_back(int'(m_data));
                if (!locked) begin
                    s = -1;
                    for (int k = 0; k < 3; k++) if (s < 0 && ex[(mptr + k) % 3].size() > 0) s = (mptr + k) % 3;
                    chk("rr_pick", m_src, s);
                    sop_src.push_back(int'(m_src));
                    locked = 1'b1;
                    cs = (s < 0) ? int'(m_src) : s;
                end
                chk("beat_pending", ex[cs].size() > 0, 1);
                if (ex[cs].size() > 0) begin
                    e = ex[cs].pop_front();
                    chk("beat", {m_src, m_sop, m_eop, m_data}, {2'(cs), e.sop, e.eop, e.data});
`ifdef RD_ARB_PARITY_CHK_EN
                    chk("parity_err", perr, e.eop && e.bad);
                    if (perr) perr_cnt++;
`endif
                    if (e.eop) begin
                        locked = 1'b0;
                        mptr = (cs + 1) % 3;
                    end
                end
            end else chk("parity_err_idle", perr, 0);
        end
    end

    task automatic push_pkt(input int s, input int len, input int base, input logic badp);
        logic [7:0] h, x, b;
        h = {6'(len), 2'(s)};
        x = h;
        fq[s].push_back(h);
        ex[s].push_back('{h, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < len; k++) begin
            b = 8'(base + k);
            x ^= b;
            fq[s].push_back(b);
            ex[s].push_back('{b, 1'b0, 1'b0, 1'b0});
        end
        b = badp ? 8'h25 : x;
        fq[s].push_back(b);
        ex[s].push_back('{b, 1'b0, 1'b1, b != x});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (ex[0].size() + ex[1].size() + ex[2].size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        chk({nm, "_done"}, n < 3000, 1);
        repeat (3) tick();
    endtask

    task automatic wait_acc(input int tgt);
        int n = 0;
        while (nacc < tgt && n < 3000) begin
            tick();
            n++;
        end
        chk("wait_acc", nacc >= tgt, 1);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        tick();
        chk({nm, "_outs"}, {rd, m_valid, m_sop, m_eop, m_src, m_data}, 0);
        chk({nm, "_perr"}, perr, 0);
        for (int i = 0; i < 3; i++) begin
            fq[i].delete();
            ex[i].delete();
        end
        locked = 1'b0;
        mptr = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int base, r, ns;
        repeat (3) tick();
        do_reset("reset");

        base = nacc; r = rdcnt[0];
        push_pkt(0, 8, 8'h40, 1'b0);
        wait_done("t1");
        chk("t1_beats", nacc - base, 10);
        chk("t1_rd_en_0", rdcnt[0] - r, 10);
        chk("t1_hdr", acc_dat[base], 8'h20);
        chk("t1_lat_rd", t_rd - t_vld, 1);
        chk("t1_lat_valid", t_mv - t_vld, 2);
        chk("t1_hdr_gap", acc_cyc[base + 1] - acc_cyc[base], 2);
        chk("t1_stream", acc_cyc[base + 9] - acc_cyc[base + 1], 8);

        do_reset("t2_reset");
        base = nacc; ns = sop_src.size();
        push_pkt(0, 4, 8'h00, 1'b0);
        push_pkt(1, 4, 8'h10, 1'b0);
        push_pkt(2, 4, 8'h20, 1'b0);
        wait_done("t2");
        chk("t2_beats", nacc - base, 18);
        chk("t2_order0", sop_src[ns], 0);
        chk("t2_order1", sop_src[ns + 1], 1);
        chk("t2_order2", sop_src[ns + 2], 2);
        chk("t2_span", acc_cyc[base + 5] - acc_cyc[base], 6);
        chk("t2_idle_gap", acc_cyc[base + 6] - acc_cyc[base + 5] >= 2, 1);
        ns = sop_src.size();
        push_pkt(1, 1, 8'h55, 1'b0);
        push_pkt(0, 0, 8'h00, 1'b0);
        wait_done("t2b");
        chk("t2b_ptr0", sop_src[ns], 0);
        chk("t2b_ptr1", sop_src[ns + 1], 1);

        base = nacc; r = rdcnt[2];
        push_pkt(2, 20, 8'h80, 1'b0);
        wait_acc(base + 6);
        m_ready = 1'b0;
        lowrd = 0;
        repeat (3) tick();
        m_ready = 1'b1;
        wait_done("t3");
        chk("t3_beats", nacc - base, 22);
        chk("t3_rd_en_2", rdcnt[2] - r, 22);
        chk("t3_rd_in_stall", lowrd, 1);

        base = nacc; r = rdcnt[1];
        push_pkt(1, 10, 8'hC0, 1'b0);
        wait_acc(base + 4);
        drop[1] = 1'b1;
        repeat (4) tick();
        drop[1] = 1'b0;
        wait_done("t4");
        chk("t4_beats", nacc - base, 12);
        chk("t4_rd_en_1", rdcnt[1] - r, 12);
        chk("t4_stalled", acc_cyc[base + 11] - acc_cyc[base] > 12, 1);

        base = nacc;
        push_pkt(2, 16, 8'h10, 1'b0);
        wait_acc(base + 4);
        do_reset("t5_mid_reset");
        ns = sop_src.size();
        push_pkt(2, 2, 8'h70, 1'b0);
        push_pkt(0, 3, 8'h60, 1'b0);
        wait_done("t5");
        chk("t5_ptr0", sop_src[ns], 0);
        chk("t5_ptr2", sop_src[ns + 1], 2);

`ifdef RD_ARB_PARITY_CHK_EN
        perr_cnt = 0;
        push_pkt(2, 14, 8'h01, 1'b1);
        wait_done("t6_bad");
        chk("t6_bad_pulses", perr_cnt, 1);
        push_pkt(2, 14, 8'h01, 1'b0);
        wait_done("t6_good");
        chk("t6_good_pulses", perr_cnt, 1);
        chk("t6_parity_byte", acc_dat[nacc - 1], 8'h35);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
